// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: mem_op bit indices, op classes,
// byte-strobe constants and the LSU state encoding.
package lsu_pkg;

    localparam int unsigned MEM_LB  = 0;
    localparam int unsigned MEM_LH  = 1;
    localparam int unsigned MEM_LW  = 2;
    localparam int unsigned MEM_LBU = 3;
    localparam int unsigned MEM_LHU = 4;
    localparam int unsigned MEM_SB  = 5;
    localparam int unsigned MEM_SH  = 6;
    localparam int unsigned MEM_SW  = 7;

    localparam logic [7:0] LOAD_OPS  = 8'h1F;
    localparam logic [7:0] STORE_OPS = 8'hE0;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: op legality, alignment, store strobes/lane data
// and sign/zero extension of the loaded word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic        store,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata,
    output logic        misalign,
    output logic        illegal
);
    logic        onehot;
    logic [31:0] sh_rdata;

    always_comb begin
        onehot   = (op != '0) && ((op & (op - 8'd1)) == '0);
        illegal  = !onehot || (store ? |(op & LOAD_OPS) : |(op & STORE_OPS));
        misalign = ((op[MEM_LH] | op[MEM_LHU] | op[MEM_SH]) & addr_lo[0]) |
                   ((op[MEM_LW] | op[MEM_SW]) & (|addr_lo));

        wstrb      = '0;
        lane_wdata = '0;
        if (op[MEM_SB]) begin
            wstrb      = STRB_B << addr_lo;
            lane_wdata = {4{wdata[7:0]}};
        end else if (op[MEM_SH]) begin
            wstrb      = STRB_H << {addr_lo[1], 1'b0};
            lane_wdata = {2{wdata[15:0]}};
        end else if (op[MEM_SW]) begin
            wstrb      = STRB_W;
            lane_wdata = wdata;
        end

        // Halfword ops are only used when aligned, so the byte shift also selects the half.
        sh_rdata  = bus_rdata >> {addr_lo, 3'b000};
        ext_rdata = '0;
        if (op[MEM_LB])       ext_rdata = {{24{sh_rdata[7]}}, sh_rdata[7:0]};
        else if (op[MEM_LH])  ext_rdata = {{16{sh_rdata[15]}}, sh_rdata[15:0]};
        else if (op[MEM_LW])  ext_rdata = bus_rdata;
        else if (op[MEM_LBU]) ext_rdata = {24'd0, sh_rdata[7:0]};
        else if (op[MEM_LHU]) ext_rdata = {16'd0, sh_rdata[15:0]};
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per request over a req/ack bus,
// with legality/alignment checks, bus timeout and a one-cycle response.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [7:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t          state, next_state;
    logic [7:0]      op_q;
    logic [31:0]     addr_q, wdata_q, rdata_q;
    logic            store_q, err_q, misalign_q;
    logic [CW-1:0]   cnt;
    logic            idle, req, reject;
    logic [7:0]      a_op;
    logic [1:0]      a_lo;
    logic            a_store;
    logic [31:0]     a_wdata;
    logic [3:0]      wstrb;
    logic [31:0]     lane_wdata, ext_rdata;
    logic            al_misalign, al_illegal;

    assign idle = (state == S_IDLE);
    assign req  = load | store;

    // The aligner checks the live request while idle and the captured one afterwards.
    assign a_op    = idle ? mem_op     : op_q;
    assign a_lo    = idle ? addr[1:0]  : addr_q[1:0];
    assign a_store = idle ? store      : store_q;
    assign a_wdata = idle ? wdata      : wdata_q;
    assign reject  = (load & store) | al_illegal;

    lsu_align u_align (
        .op         (a_op),
        .addr_lo    (a_lo),
        .store      (a_store),
        .wdata      (a_wdata),
        .bus_rdata  (bus_rdata),
        .wstrb      (wstrb),
        .lane_wdata (lane_wdata),
        .ext_rdata  (ext_rdata),
        .misalign   (al_misalign),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (req) next_state = (reject || al_misalign) ? S_RESP : S_BUS;
            S_BUS:   if (bus_ack || cnt == TMO_LAST) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    op_q       <= mem_op;
                    addr_q     <= addr;
                    wdata_q    <= wdata;
                    store_q    <= store;
                    cnt        <= '0;
                    err_q      <= reject;
                    misalign_q <= !reject && al_misalign;
                    if (reject || al_misalign) rdata_q <= '0;
                end
                S_BUS: begin
                    if (bus_ack) begin
                        rdata_q <= store_q ? '0 : ext_rdata;
                    end else if (cnt == TMO_LAST) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall      = (idle & req) | (state == S_BUS);
    assign resp_valid = (state == S_RESP);
    assign misalign   = resp_valid & misalign_q;
    assign bus_err    = resp_valid & err_q;
    assign rdata      = rdata_q;
    assign bus_req    = (state == S_BUS);
    assign bus_we     = bus_req & store_q;
    assign bus_addr   = bus_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus_wstrb  = bus_req ? wstrb : '0;
    assign bus_wdata  = bus_req ? lane_wdata : '0;

endmodule
